// File: rtl/bus_wait_injector.sv
// Purpose : Avalon-style stage between a CPU master and a memory slave that injects
//           a fixed or LFSR-driven number of wait cycles and flags master protocol violations.
// Latency : accept edge -> completion cycle = 1 + (stall+1) + 1 cycles when slave waitrequest=0.
// Backpressure: master is stalled (m_waitrequest=1) in every state except RESP; slave
//           waitrequest holds the strobe in ISSUE.
//
// Ports:
//   clk, reset (sync, active-low)
//   m_*  : master side (address/read/write/writedata/byteenable in; waitrequest/readdata out)
//   s_*  : slave side (latched address/read/write/writedata/byteenable out; waitrequest/readdata in)
//   protocol_error : sticky master-violation flag
//   txn_count      : completed transactions (wraps)
module bus_wait_injector #(
    parameter int          WAIT_MODE  = 0,
    parameter logic [3:0]  FIXED_WAIT = 4'd2,
    parameter logic [3:0]  WAIT_MASK  = 4'hF,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_address,
    input  logic        m_read,
    input  logic        m_write,
    input  logic [31:0] m_writedata,
    input  logic [3:0]  m_byteenable,
    output logic        m_waitrequest,
    output logic [31:0] m_readdata,
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    output logic        protocol_error,
    output logic [31:0] txn_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        ISSUE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        op_wr_q, op_wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        perr_q, perr_d;
    logic [31:0] txn_q, txn_d;
    logic        viol;

    // Galois LFSR, x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // The master must hold the exact request it was accepted with until RESP.
    assign viol = (m_address != addr_q) || (m_writedata != wdata_q) ||
                  (m_byteenable != be_q) || (m_write != op_wr_q) ||
                  (m_read != ~op_wr_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        op_wr_d = op_wr_q;
        rdata_d = rdata_q;
        perr_d  = perr_q;
        txn_d   = txn_q;

        case (state_q)
            IDLE: begin
                if (m_read || m_write) begin
                    addr_d  = m_address;
                    wdata_d = m_writedata;
                    be_d    = m_byteenable;
                    // Simultaneous read+write is an error; resolve it as a read.
                    op_wr_d = m_write & ~m_read;
                    if (m_read && m_write) begin
                        perr_d = 1'b1;
                    end
                    if (WAIT_MODE == 1) begin
                        cnt_d  = lfsr_q[3:0] & WAIT_MASK;
                        lfsr_d = lfsr_step(lfsr_q);
                    end else begin
                        cnt_d = FIXED_WAIT;
                    end
                    state_d = STALL;
                end
            end
            STALL: begin
                if (cnt_q == 4'd0) begin
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ISSUE: begin
                if (!s_waitrequest) begin
                    if (!op_wr_q) begin
                        rdata_d = s_readdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                txn_d   = txn_q + 32'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if ((state_q == STALL || state_q == ISSUE) && viol) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            lfsr_q  <= LFSR_SEED;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            op_wr_q <= 1'b0;
            rdata_q <= 32'd0;
            perr_q  <= 1'b0;
            txn_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            op_wr_q <= op_wr_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
            txn_q   <= txn_d;
        end
    end

    // Outputs decode from registered state only.
    assign m_waitrequest  = (state_q != RESP);
    assign m_readdata     = rdata_q;
    assign s_read         = (state_q == ISSUE) && !op_wr_q;
    assign s_write        = (state_q == ISSUE) && op_wr_q;
    assign s_address      = addr_q;
    assign s_writedata    = wdata_q;
    assign s_byteenable   = be_q;
    assign protocol_error = perr_q;
    assign txn_count      = txn_q;

endmodule

// File: tb/tb_bus_wait_injector.sv
module tb_bus_wait_injector;

    logic        clk = 1'b0;
    logic        rst_n          [3];
    logic [31:0] m_address      [3];
    logic        m_read         [3];
    logic        m_write        [3];
    logic [31:0] m_writedata    [3];
    logic [3:0]  m_byteenable   [3];
    logic        m_waitrequest  [3];
    logic [31:0] m_readdata     [3];
    logic [31:0] s_address      [3];
    logic        s_read         [3];
    logic        s_write        [3];
    logic [31:0] s_writedata    [3];
    logic [3:0]  s_byteenable   [3];
    logic        s_waitrequest  [3];
    logic [31:0] s_readdata     [3];
    logic        protocol_error [3];
    logic [31:0] txn_count      [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance 0: fixed 2, instance 1: fixed 0, instance 2: LFSR mode.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        bus_wait_injector #(
            .WAIT_MODE  ((g == 2) ? 1 : 0),
            .FIXED_WAIT ((g == 0) ? 4'd2 : 4'd0),
            .WAIT_MASK  (4'hF),
            .LFSR_SEED  (16'hACE1)
        ) u_dut (
            .clk            (clk),
            .reset          (rst_n[g]),
            .m_address      (m_address[g]),
            .m_read         (m_read[g]),
            .m_write        (m_write[g]),
            .m_writedata    (m_writedata[g]),
            .m_byteenable   (m_byteenable[g]),
            .m_waitrequest  (m_waitrequest[g]),
            .m_readdata     (m_readdata[g]),
            .s_address      (s_address[g]),
            .s_read         (s_read[g]),
            .s_write        (s_write[g]),
            .s_writedata    (s_writedata[g]),
            .s_byteenable   (s_byteenable[g]),
            .s_waitrequest  (s_waitrequest[g]),
            .s_readdata     (s_readdata[g]),
            .protocol_error (protocol_error[g]),
            .txn_count      (txn_count[g])
        );

        // Slave memory, 64 words, reloaded while its DUT is in reset.
        logic [31:0] mem [64];
        always @(posedge clk) begin
            if (!rst_n[g]) begin
                for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | i;
                mem[1] <= 32'h2402_0005;
                mem[4] <= 32'h1122_3344;
            end else if (s_write[g] && !s_waitrequest[g]) begin
                for (int b = 0; b < 4; b++)
                    if (s_byteenable[g][b])
                        mem[s_address[g][7:2]][8*b +: 8] <= s_writedata[g][8*b +: 8];
            end
        end
        assign s_readdata[g] = mem[s_address[g][7:2]];
    end

    function automatic logic [15:0] lfsr_model(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a[7:2])
            6'd1:    return 32'h2402_0005;
            6'd4:    return 32'h1122_3344;
            default: return 32'hA500_0000 | {26'd0, a[7:2]};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs(input int k);
        m_address[k]    = 32'd0;
        m_read[k]       = 1'b0;
        m_write[k]      = 1'b0;
        m_writedata[k]  = 32'd0;
        m_byteenable[k] = 4'd0;
    endtask

    // One transaction: lat = cycles after the accept edge until the RESP cycle.
    task automatic txn(input int k, input logic [31:0] a, input logic rd, input logic wr,
                       input logic [31:0] wd, input logic [3:0] be,
                       output int lat, output int nrd, output int nwr,
                       output logic [31:0] rdata, output logic [31:0] saddr,
                       output logic [31:0] swd, output logic [3:0] sbe);
        lat = -1; nrd = 0; nwr = 0; rdata = 'x; saddr = 'x; swd = 'x; sbe = 'x;
        @(negedge clk);
        m_address[k] = a; m_read[k] = rd; m_write[k] = wr;
        m_writedata[k] = wd; m_byteenable[k] = be;
        @(posedge clk);
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            if (s_read[k]) nrd++;
            if (s_write[k]) begin
                nwr++; swd = s_writedata[k]; sbe = s_byteenable[k];
            end
            if (s_read[k] || s_write[k]) saddr = s_address[k];
            if (!m_waitrequest[k]) begin
                lat = n; rdata = m_readdata[k];
                break;
            end
        end
        idle_inputs(k);
        @(negedge clk);
    endtask

    initial begin
        int lat, nrd, nwr, sr, mwlow;
        logic done;
        logic [31:0] rdata, saddr, swd;
        logic [3:0]  sbe;
        logic [15:0] l;

        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; s_waitrequest[k] = 1'b0; idle_inputs(k);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_waitreq%0d", k), {31'd0, m_waitrequest[k]}, 32'd1);
            chk($sformatf("rst_sread%0d", k),   {31'd0, s_read[k]}, 32'd0);
            chk($sformatf("rst_swrite%0d", k),  {31'd0, s_write[k]}, 32'd0);
            chk($sformatf("rst_rdata%0d", k),   m_readdata[k], 32'd0);
            chk($sformatf("rst_perr%0d", k),    {31'd0, protocol_error[k]}, 32'd0);
            chk($sformatf("rst_txn%0d", k),     txn_count[k], 32'd0);
            chk($sformatf("rst_saddr%0d", k),   s_address[k], 32'd0);
        end
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        @(negedge clk);

        // Fixed stall of 2: completion 5 cycles after accept.
        txn(0, 32'h4, 1'b1, 1'b0, 32'd0, 4'hF, lat, nrd, nwr, rdata, saddr, swd, sbe);
        chk("m0_lat", lat, 32'd5);
        chk("m0_rdata", rdata, 32'h2402_0005);
        chk("m0_nrd", nrd, 32'd1);
        chk("m0_txn", txn_count[0], 32'd1);
        chk("m0_perr", {31'd0, protocol_error[0]}, 32'd0);

        // Zero stall: partial write then read-back of the merged word.
        txn(1, 32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0011, lat, nrd, nwr, rdata, saddr, swd, sbe);
        chk("wr_lat", lat, 32'd3);
        chk("wr_nwr", nwr, 32'd1);
        chk("wr_nrd", nrd, 32'd0);
        chk("wr_swd", swd, 32'hDEAD_BEEF);
        chk("wr_sbe", {28'd0, sbe}, 32'h3);
        chk("wr_saddr", saddr, 32'h10);
        chk("wr_rdata_kept", rdata, 32'd0);
        txn(1, 32'h10, 1'b1, 1'b0, 32'd0, 4'hF, lat, nrd, nwr, rdata, saddr, swd, sbe);
        chk("rd_merged", rdata, 32'h1122_BEEF);
        chk("rd_lat", lat, 32'd3);
        chk("rd_txn", txn_count[1], 32'd2);
        chk("rd_perr", {31'd0, protocol_error[1]}, 32'd0);

        // LFSR mode: stalls follow the software Galois model (1, 0, 8, 12 for ACE1).
        l = 16'hACE1;
        for (int i = 0; i < 4; i++) begin
            int exp_lat;
            exp_lat = int'(l[3:0] & 4'hF) + 3;
            l = lfsr_model(l);
            txn(2, 32'(i * 4), 1'b1, 1'b0, 32'd0, 4'hF, lat, nrd, nwr, rdata, saddr, swd, sbe);
            chk($sformatf("lfsr_lat%0d", i), lat, exp_lat);
            chk($sformatf("lfsr_rdata%0d", i), rdata, init_word(32'(i * 4)));
        end
        chk("lfsr_txn", txn_count[2], 32'd4);

        // Slave stall of 3 cycles in ISSUE.
        s_waitrequest[1] = 1'b1;
        @(negedge clk);
        m_address[1] = 32'h8; m_read[1] = 1'b1; m_byteenable[1] = 4'hF;
        @(posedge clk);
        sr = 0; mwlow = 0; done = 1'b0; rdata = 'x;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            if (!m_waitrequest[1]) begin
                done = 1'b1; rdata = m_readdata[1];
                chk("sw_sread_off", {31'd0, s_read[1]}, 32'd0);
                break;
            end
            if (s_read[1]) begin
                sr++;
                if (sr == 4) s_waitrequest[1] = 1'b0;
            end
        end
        idle_inputs(1);
        chk("sw_done", {31'd0, done}, 32'd1);
        chk("sw_sread_cycles", sr, 32'd4);
        chk("sw_rdata", rdata, 32'hA500_0002);
        @(negedge clk);

        // Address change during STALL.
        @(negedge clk);
        m_address[0] = 32'h8; m_read[0] = 1'b1; m_byteenable[0] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        chk("pe_before", {31'd0, protocol_error[0]}, 32'd0);
        m_address[0] = 32'hC;
        @(negedge clk);
        chk("pe_set", {31'd0, protocol_error[0]}, 32'd1);
        done = 1'b0; saddr = 'x; rdata = 'x;
        for (int n = 1; n <= 64; n++) begin
            if (s_read[0]) saddr = s_address[0];
            if (!m_waitrequest[0]) begin
                done = 1'b1; rdata = m_readdata[0];
                break;
            end
            @(negedge clk);
        end
        idle_inputs(0);
        chk("pe_done", {31'd0, done}, 32'd1);
        chk("pe_saddr", saddr, 32'h8);
        chk("pe_rdata", rdata, 32'hA500_0002);
        repeat (3) @(negedge clk);
        chk("pe_sticky", {31'd0, protocol_error[0]}, 32'd1);
        chk("pe_txn", txn_count[0], 32'd2);

        // Read and write together: flagged, handled as a read, memory untouched.
        txn(1, 32'h4, 1'b1, 1'b1, 32'h5555_5555, 4'hF, lat, nrd, nwr, rdata, saddr, swd, sbe);
        chk("rw_perr", {31'd0, protocol_error[1]}, 32'd1);
        chk("rw_nwr", nwr, 32'd0);
        chk("rw_nrd", nrd, 32'd1);
        chk("rw_rdata", rdata, 32'h2402_0005);
        txn(1, 32'h4, 1'b1, 1'b0, 32'd0, 4'hF, lat, nrd, nwr, rdata, saddr, swd, sbe);
        chk("rw_mem_intact", rdata, 32'h2402_0005);

        // Reset while in ISSUE.
        s_waitrequest[2] = 1'b1;
        @(negedge clk);
        m_address[2] = 32'h0; m_read[2] = 1'b1; m_byteenable[2] = 4'hF;
        @(posedge clk);
        done = 1'b0;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            if (s_read[2]) begin
                done = 1'b1;
                break;
            end
        end
        chk("rst_reached_issue", {31'd0, done}, 32'd1);
        rst_n[2] = 1'b0;
        idle_inputs(2);
        @(posedge clk);
        #1;
        chk("mid_rst_sread", {31'd0, s_read[2]}, 32'd0);
        chk("mid_rst_waitreq", {31'd0, m_waitrequest[2]}, 32'd1);
        chk("mid_rst_txn", txn_count[2], 32'd0);
        chk("mid_rst_rdata", m_readdata[2], 32'd0);
        @(negedge clk);
        rst_n[2] = 1'b1;
        s_waitrequest[2] = 1'b0;
        // Seed reload: first stall is ACE1[3:0] = 1, latency 4.
        txn(2, 32'h4, 1'b1, 1'b0, 32'd0, 4'hF, lat, nrd, nwr, rdata, saddr, swd, sbe);
        chk("post_rst_lat", lat, 32'd4);
        chk("post_rst_rdata", rdata, 32'h2402_0005);
        chk("post_rst_txn", txn_count[2], 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bus_wait_injector.md
Name: bus_wait_injector

Overview:
- Avalon-style bus stage between the mips_cpu_bus master port and the request_memory slave.
- Accepts one master transaction at a time and inserts a programmable or pseudorandom number of extra wait cycles. It then forwards the latched request to the memory and returns registered read data.
- Used in CPU testbenches to stress-test the CPU's waitrequest handling and to flag master protocol violations.

Parameters:
- WAIT_MODE, 0, 0 = fixed stall of FIXED_WAIT cycles; 1 = pseudorandom stall from the LFSR.
- FIXED_WAIT, 2, stall length in mode 0 (0..15).
- WAIT_MASK, 4'hF, AND-mask applied to lfsr[3:0] in mode 1.
- LFSR_SEED, 16'hACE1, LFSR value loaded on reset; must be nonzero.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- m_address  in  32  master byte address.
- m_read  in  1  master read request.
- m_write  in  1  master write request.
- m_writedata  in  32  master write data.
- m_byteenable  in  4  master byte enables.
- m_waitrequest  out  1  stall to master.
- m_readdata  out  32  read data to master.
- s_address  out  32  slave address (latched copy).
- s_read  out  1  slave read strobe.
- s_write  out  1  slave write strobe.
- s_writedata  out  32  slave write data (latched).
- s_byteenable  out  4  slave byte enables (latched).
- s_waitrequest  in  1  slave stall.
- s_readdata  in  32  slave read data.
- protocol_error  out  1  sticky violation flag.
- txn_count  out  32  completed transactions.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; s_read=s_write=0; m_readdata=0; protocol_error=0; txn_count=0; lfsr=LFSR_SEED.
  - Latched address, writedata and byteenable registers = 0.
  - Reset mid-transaction abandons it: slave strobes drop on that edge and no count increment occurs.
- m_waitrequest decodes from state only: 0 in RESP, 1 in every other state, including IDLE. It never depends combinationally on m_read/m_write.
- State IDLE:
  - When m_read|m_write is high, latch address, writedata, byteenable and op, then enter STALL.
  - Load cnt: FIXED_WAIT in mode 0, or lfsr[3:0]&WAIT_MASK in mode 1.
  - In mode 1, advance the LFSR once on this accept. Galois form, taps x^16+x^14+x^13+x^11+1; shift right, XOR 16'hB400 when the outgoing lsb is 1.
  - If m_read and m_write are both high: set protocol_error and treat the transaction as a read.
- State STALL:
  - cnt==0: go to ISSUE on the next edge. A zero stall therefore still costs exactly one STALL cycle.
  - Otherwise decrement cnt.
- State ISSUE:
  - s_read/s_write driven from the latched op; s_* data comes from the latched registers.
  - When s_waitrequest==0: capture s_readdata into m_readdata (reads only; writes leave m_readdata unchanged) and go to RESP.
  - Strobes deassert on the edge leaving ISSUE.
- State RESP:
  - m_waitrequest=0 for exactly one cycle; txn_count increments on this edge (wraps at 2^32); go to IDLE.
  - A new request presented during RESP is not accepted until IDLE (back-to-back gap of one cycle).
- Minimum latency, read with slave waitrequest=0, from IDLE accept edge to the master completion cycle: 1 + (stall+1) + 1 cycles.
- Protocol check: in STALL or ISSUE, set protocol_error (sticky until reset) if any of the following holds:
  - m_address, m_writedata or m_byteenable differ from the latched values;
  - m_read/m_write differ from the latched op;
  - both m_read and m_write are low.
- The transaction still completes using the latched values.
- LFSR advances only on accepts, so the stall sequence is deterministic for a given seed.

Test Plan:
- Mode 0, FIXED_WAIT=2: master reads 0x00000004, memory holds 0x24020005 there, slave waitrequest=0 -> m_waitrequest low in exactly one cycle, 5 cycles after accept; m_readdata=0x24020005; txn_count=1; protocol_error=0.
- Mode 0, FIXED_WAIT=0: write 0xDEADBEEF, byteenable 4'b0011 to 0x10 -> single-cycle s_write with latched data/enables; followed by a read of 0x10 -> returns the merged value; txn_count=2.
- Mode 1, seed 16'hACE1, mask 4'hF, 4 back-to-back reads -> stall lengths match a software Galois-LFSR model; each completion returns the correct memory word.
- Slave holds s_waitrequest high for 3 cycles in ISSUE -> s_read stays high 4 cycles; m_waitrequest stays high throughout; completion follows.
- Master changes m_address from 0x8 to 0xC during STALL -> protocol_error=1 and stays 1; the slave sees address 0x8.
- reset driven low during ISSUE -> next edge s_read=0, state IDLE, txn_count=0, lfsr=LFSR_SEED; a subsequent read completes normally.
